// File: rtl/mem_responder.sv
// mem_responder: tagged main-memory model for the processor/cache bus.
// Loads return after a fixed latency; stores write the array directly.
package mem_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;
endpackage

module mem_responder
  import mem_pkg::*;
#(
  parameter int NUM_MEM_TAGS = 15,
  parameter int MEM_LATENCY  = 10,
  parameter int MEM_DEPTH    = 8192,
  parameter int DATA_SIZE    = 64,
  localparam int TAG_W = $clog2(NUM_MEM_TAGS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  BUS_COMMAND           proc2mem_command,
  input  logic [31:0]          proc2mem_addr,
  input  logic [DATA_SIZE-1:0] proc2mem_data,
  input  logic                 mem_init_en,
  input  logic [31:0]          mem_init_addr,
  input  logic [DATA_SIZE-1:0] mem_init_data,
  output logic [TAG_W-1:0]     mem2proc_response,
  output logic [DATA_SIZE-1:0] mem2proc_data,
  output logic [TAG_W-1:0]     mem2proc_tag
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  // Counter holds the edges still to pass before the returning edge.
  localparam logic [CW-1:0] CNT_INIT =
    (MEM_LATENCY > 1) ? CW'(MEM_LATENCY - 2) : '0;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
  logic [NUM_MEM_TAGS:1] busy;
  logic [NUM_MEM_TAGS:1] done_vec;
  logic [CW-1:0] cnt [NUM_MEM_TAGS:1];
  logic [DATA_SIZE-1:0] line [NUM_MEM_TAGS:1];

  logic [TAG_W-1:0] free_tag;
  logic [28:0] bus_idx;
  logic [28:0] init_idx;
  logic bus_ok;
  logic init_ok;
  logic bus_cmd;
  logic accept;
  logic ld_acc;
  logic st_acc;
  logic [DATA_SIZE-1:0] rd_line;
  logic unused_low;

  assign unused_low = ^{proc2mem_addr[2:0], mem_init_addr[2:0]};

  assign bus_idx  = proc2mem_addr[31:3];
  assign init_idx = mem_init_addr[31:3];
  assign bus_ok   = 32'(bus_idx) < 32'(MEM_DEPTH);
  assign init_ok  = 32'(init_idx) < 32'(MEM_DEPTH);

  always_comb begin
    free_tag = '0;
    for (int t = NUM_MEM_TAGS; t >= 1; t--)
      if (!busy[t]) free_tag = TAG_W'(t);
  end

  assign bus_cmd = (proc2mem_command == BUS_LOAD) ||
                   (proc2mem_command == BUS_STORE);
  assign accept  = !reset && !mem_init_en && bus_cmd &&
                   (free_tag != '0);
  assign ld_acc  = accept && (proc2mem_command == BUS_LOAD);
  assign st_acc  = accept && (proc2mem_command == BUS_STORE);

  assign mem2proc_response = accept ? free_tag : '0;

  assign rd_line = bus_ok ? mem[bus_idx[AW-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (mem_init_en && init_ok)
      mem[init_idx[AW-1:0]] <= mem_init_data;
    else if (st_acc && bus_ok)
      mem[bus_idx[AW-1:0]] <= proc2mem_data;
  end

  always_ff @(posedge clock) begin
    if (ld_acc)
      line[free_tag] <= rd_line;
  end

  always_comb begin
    done_vec = '0;
    for (int t = 1; t <= NUM_MEM_TAGS; t++)
      done_vec[t] = busy[t] && (cnt[t] == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      mem2proc_tag  <= '0;
      mem2proc_data <= '0;
      for (int t = 1; t <= NUM_MEM_TAGS; t++)
        cnt[t] <= '0;
    end else begin
      mem2proc_tag  <= '0;
      mem2proc_data <= '0;
      for (int t = 1; t <= NUM_MEM_TAGS; t++) begin
        if (done_vec[t]) begin
          busy[t]       <= 1'b0;
          mem2proc_tag  <= TAG_W'(t);
          mem2proc_data <= line[t];
        end else if (busy[t]) begin
          cnt[t] <= cnt[t] - 1'b1;
        end
      end
      if (ld_acc) begin
        if (MEM_LATENCY == 1) begin
          mem2proc_tag  <= free_tag;
          mem2proc_data <= rd_line;
        end else begin
          busy[free_tag] <= 1'b1;
          cnt[free_tag]  <= CNT_INIT;
        end
      end
    end
  end

  a_one_done: assert property (
    @(posedge clock) disable iff (reset) $onehot0(done_vec)
  );

endmodule
